// File: rtl/line_follow_ctrl.sv
// line_follow_ctrl: debounced two-sensor line follower with dead time between motion codes; LINE_SEARCH_EN adds search/halt
module line_follow_ctrl #(
  parameter int DEB_CYCLES  = 1000,
  parameter int DEAD_CYCLES = 100,
  parameter int LOST_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       sens_l,
  input  logic       sens_r,
  output logic [1:0] state,
  output logic       lost,
  output logic       halted
);
  typedef enum logic [2:0] {IDLE, FWD, LEFT, RIGHT, DEAD
`ifdef LINE_SEARCH_EN
    , SEARCH, HALT
`endif
  } st_e;
  // sensor vectors: bit 1 = left, bit 0 = right, so the filtered pair is the target motion code
  logic [1:0]  sy1_q, sy2_q, filt_q, filt_d;
  logic [15:0] cnt_q [2];
  logic [15:0] cnt_d [2];
  st_e         fsm_q, fsm_d, tgt;
  logic        side_q, side_d;
  logic [15:0] tmr_q, tmr_d;
  logic [1:0]  state_d;
`ifdef LINE_SEARCH_EN
  logic        lost_d, halted_d;
  localparam st_e LOST_ST = SEARCH;
`else
  localparam st_e LOST_ST = IDLE;
`endif

  // motion code driven while in state s; search sweeps toward the side last seen (left = 1)
  function automatic logic [1:0] code_of(st_e s, logic left);
    logic srch;
`ifdef LINE_SEARCH_EN
    srch = s == SEARCH;
`else
    srch = 1'b0;
`endif
    return {s == FWD || s == LEFT || (srch && left), s == FWD || s == RIGHT || (srch && !left)};
  endfunction

  // a switch between two different nonzero codes must pass through a forced stop
  function automatic st_e route(st_e t, logic [1:0] cur, logic left);
    logic [1:0] c;
    c = code_of(t, left);
    return (c != 2'b00 && cur != 2'b00 && c != cur) ? DEAD : t;
  endfunction

  // per-sensor debounce: filtered value flips after DEB_CYCLES consecutive disagreeing samples
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      filt_d[i] = filt_q[i];
      cnt_d[i]  = '0;
      if (sy2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == 16'(DEB_CYCLES - 1)) filt_d[i] = ~filt_q[i];
        else cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  // synchronizers and debounce state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sy1_q  <= '0;
      sy2_q  <= '0;
      filt_q <= '0;
      cnt_q  <= '{16'd0, 16'd0};
    end else begin
      sy1_q  <= {sens_l, sens_r};
      sy2_q  <= sy1_q;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  // next motion state, shared timer and registered output values
  always_comb begin
    tgt   = filt_q == 2'b11 ? FWD : filt_q == 2'b10 ? LEFT : filt_q == 2'b01 ? RIGHT : LOST_ST;
    fsm_d = route(tgt, state_q_w(), side_q);
    if (!en) fsm_d = IDLE;
    else if (fsm_q == DEAD) fsm_d = tmr_q == 16'(DEAD_CYCLES - 1) ? tgt : DEAD;
`ifdef LINE_SEARCH_EN
    else if (fsm_q == HALT) fsm_d = HALT;
    else if (fsm_q == SEARCH && filt_q == 2'b00) fsm_d = tmr_q == 16'(LOST_CYCLES - 1) ? HALT : SEARCH;
`endif
    side_d  = fsm_d == LEFT ? 1'b1 : fsm_d == RIGHT ? 1'b0 : side_q;
    tmr_d   = fsm_d != fsm_q ? 16'd0 : tmr_q == 16'hffff ? tmr_q : tmr_q + 16'd1;
    state_d = code_of(fsm_d, side_d);
`ifdef LINE_SEARCH_EN
    lost_d   = fsm_d == SEARCH;
    halted_d = fsm_d == HALT;
`endif
  end

  function automatic logic [1:0] state_q_w();
    return state;
  endfunction

  // FSM and its outputs update on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q  <= IDLE;
      side_q <= 1'b0;
      tmr_q  <= '0;
      state  <= 2'b00;
`ifdef LINE_SEARCH_EN
      lost   <= 1'b0;
      halted <= 1'b0;
`endif
    end else begin
      fsm_q  <= fsm_d;
      side_q <= side_d;
      tmr_q  <= tmr_d;
      state  <= state_d;
`ifdef LINE_SEARCH_EN
      lost   <= lost_d;
      halted <= halted_d;
`endif
    end
  end

`ifndef LINE_SEARCH_EN
  assign lost   = 1'b0;
  assign halted = 1'b0;
`endif
endmodule

// File: tb/tb_line_follow_ctrl.sv
// tb_line_follow_ctrl: directed vector table plus random run against a behavioural model (build with or without LINE_SEARCH_EN)
module tb_line_follow_ctrl;
  localparam int DEB = 4, DEADC = 3, LOSTC = 10;
`ifdef LINE_SEARCH_EN
  localparam bit SE = 1'b1;
`else
  localparam bit SE = 1'b0;
`endif
  localparam int STOP = 0, MOVE = 1, DWELL = 2, SRCH = 3, HLT = 4;

  logic clk = 1'b0, rst_n, en, sens_l, sens_r, lost, halted;
  logic [1:0] state;
  int n_chk = 0, n_fail = 0;

  line_follow_ctrl #(.DEB_CYCLES(DEB), .DEAD_CYCLES(DEADC), .LOST_CYCLES(LOSTC)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sens_l(sens_l), .sens_r(sens_r),
    .state(state), .lost(lost), .halted(halted)
  );

  // free-running clock
  always #5 clk = ~clk;

  // model: sync pipeline, debounce counts, motion mode/code, timer, last side (1 = left)
  bit   ms1 [2], ms2 [2], mf [2];
  int   mc [2];
  int   mmode, mt;
  bit [1:0] mcode;
  bit   mleft;

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin ms1[i] = 0; ms2[i] = 0; mf[i] = 0; mc[i] = 0; end
    mmode = STOP; mt = 0; mcode = 2'b00; mleft = 1'b0;
  endtask

  task automatic m_step();
    bit [1:0] line, want_code;
    int want_mode;
    line      = {mf[1], mf[0]};
    want_code = line != 0 ? line : (SE ? (mleft ? 2'b10 : 2'b01) : 2'b00);
    want_mode = line != 0 ? MOVE : (SE ? SRCH : STOP);
    if (!en) begin mmode = STOP; mcode = 0; mt = 0; end
    else if (mmode == HLT) mt++;
    else if (mmode == DWELL) begin
      if (mt == DEADC - 1) begin mmode = want_mode; mcode = want_code; mt = 0; end
      else mt++;
    end else if (mmode == SRCH && line == 0) begin
      if (mt == LOSTC - 1) begin mmode = HLT; mcode = 0; mt = 0; end
      else mt++;
    end else if (mcode != 0 && want_code != 0 && want_code != mcode) begin mmode = DWELL; mcode = 0; mt = 0; end
    else if (want_mode != mmode || want_code != mcode) begin mmode = want_mode; mcode = want_code; mt = 0; end
    else mt++;
    if (mmode == MOVE && mcode == 2'b10) mleft = 1'b1;
    if (mmode == MOVE && mcode == 2'b01) mleft = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (ms2[i] != mf[i]) begin
        if (mc[i] + 1 >= DEB) begin mf[i] = ms2[i]; mc[i] = 0; end
        else mc[i]++;
      end else mc[i] = 0;
      ms2[i] = ms1[i];
    end
    ms1[1] = sens_l;
    ms1[0] = sens_r;
  endtask

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk3(string nm, int st, int lo, int ha);
    chk({nm, ".state"}, int'(state), st);
    chk({nm, ".lost"}, int'(lost), lo);
    chk({nm, ".halted"}, int'(halted), ha);
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst_n) m_step();
    #1;
  endtask

  typedef struct {bit e, l, r; int n; int st, lo, ha;} vec_t;
  vec_t tbl [$];

  initial begin
    rst_n = 0; en = 0; sens_l = 0; sens_r = 0;
    m_reset();
    // expected values after each held segment, worked out by hand from the timing rules
    tbl.push_back('{0, 1, 1, 8, 0, 0, 0});
    tbl.push_back('{1, 1, 1, 1, 3, 0, 0});
    tbl.push_back('{1, 1, 0, 6, 3, 0, 0});
    tbl.push_back('{1, 1, 0, 1, 0, 0, 0});
    tbl.push_back('{1, 1, 0, 2, 0, 0, 0});
    tbl.push_back('{1, 1, 0, 1, 2, 0, 0});
    tbl.push_back('{1, 1, 0, 5, 2, 0, 0});
    tbl.push_back('{1, 1, 1, 7, 0, 0, 0});
    tbl.push_back('{0, 1, 1, 1, 0, 0, 0});
    tbl.push_back('{1, 1, 1, 1, 3, 0, 0});
    tbl.push_back('{1, 0, 0, 6, 3, 0, 0});
    tbl.push_back('{1, 0, 0, 1, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 3, SE ? 2 : 0, SE, 0});
    tbl.push_back('{1, 0, 0, 9, SE ? 2 : 0, SE, 0});
    tbl.push_back('{1, 0, 0, 1, 0, 0, SE});
    tbl.push_back('{1, 1, 1, 8, SE ? 0 : 3, 0, SE});
    tbl.push_back('{0, 1, 1, 1, 0, 0, 0});

    repeat (2) @(posedge clk);
    #1;
    chk3("reset", 0, 0, 0);
    rst_n = 1;

`ifdef LINE_SEARCH_EN
    en = 0; sens_l = 1; sens_r = 0;
    repeat (8) cyc();
    en = 1;
    cyc();
    chk3("left_entry", 2, 0, 0);
    sens_l = 0;
    repeat (6) cyc();
    chk3("left_hold", 2, 0, 0);
    cyc();
    chk3("search_entry", 2, 1, 0);
    en = 0;
    cyc();
    chk3("search_abort", 0, 0, 0);
`else
    en = 1;
    sens_l = 1; sens_r = 1;
    repeat (3) cyc();
    sens_l = 0; sens_r = 0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk($sformatf("glitch%0d.state", k), int'(state), 0);
    end
    sens_l = 1; sens_r = 1;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      chk($sformatf("deb_edge%0d.state", k), int'(state), k == 7 ? 3 : 0);
    end
    en = 0;
    sens_l = 0; sens_r = 0;
    repeat (8) cyc();
`endif

    foreach (tbl[i]) begin
      en = tbl[i].e; sens_l = tbl[i].l; sens_r = tbl[i].r;
      repeat (tbl[i].n) cyc();
      chk3($sformatf("vec%0d", i), tbl[i].st, tbl[i].lo, tbl[i].ha);
    end

    en = 1;
    cyc();
    chk3("pre_reset", 3, 0, 0);
    #2 rst_n = 0;
    #1;
    chk3("async_reset", 0, 0, 0);
    m_reset();
    cyc();
    rst_n = 1;

    en = 1; sens_l = 0; sens_r = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 11) == 0) {sens_l, sens_r} = 2'($urandom_range(0, 3));
      en = en ? ($urandom_range(0, 99) != 0) : ($urandom_range(0, 3) == 0);
      if (c == 1500) begin
        #2 rst_n = 0;
        #1 m_reset();
        chk3("rand_reset", 0, 0, 0);
        cyc();
        rst_n = 1;
      end
      cyc();
      chk3($sformatf("rand%0d", c), int'(mcode), int'(mmode == SRCH), int'(mmode == HLT));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
